// File: rtl/glitch_sequencer.sv
// glitch_sequencer: programmable train of N glitch pulses launched by a synchronised trigger edge.
// Optional random delay dither is compiled in with `define GLITCH_SEQ_DITHER_EN.
module glitch_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PULSES_W    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DITHER_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                trigger,
  input  logic                cfg_edge,
  input  logic [CNT_W-1:0]    cfg_delay,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CNT_W-1:0]    cfg_gap,
  input  logic [PULSES_W-1:0] cfg_count,
  output logic                glitch,
  output logic                busy,
  output logic                delay_active,
  output logic                done,
  output logic [PULSES_W-1:0] pulse_idx
);

  localparam int unsigned      SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_N-1:0]   sync_q;
  logic                trig_prev_q;
  logic                edge_q, edge_d;
  logic                trig_s, trig_idle;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PULSES_W-1:0] pulse_idx_q, pulse_idx_d;
  logic                latch_cfg;

  logic                cfg_edge_q;
  logic [CNT_W-1:0]    cfg_delay_q, cfg_width_q, cfg_gap_q;
  logic [PULSES_W-1:0] cfg_count_q;

  logic [DITHER_W-1:0] dither_r;
  logic [CNT_W:0]      delay_sum;
  logic [CNT_W-1:0]    delay_eff, width_eff, gap_eff;
  logic [PULSES_W-1:0] count_eff;

  logic glitch_q, glitch_d;
  logic busy_q, busy_d;
  logic delay_active_q, delay_active_d;
  logic done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_N-2:0], trigger};
      trig_prev_q <= trig_s;
      edge_q      <= edge_d;
    end
  end

  assign trig_s = sync_q[SYNC_N-1];

  // Edge is registered once more so first-pulse latency is SYNC_STAGES + 1 + D.
  always_comb begin
    edge_d    = cfg_edge_q ? (trig_prev_q & ~trig_s) : (trig_s & ~trig_prev_q);
    trig_idle = (trig_s == cfg_edge_q);
  end

`ifdef GLITCH_SEQ_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign dither_r = lfsr_q[DITHER_W-1:0];
`else
  assign dither_r = '0;
`endif

  // Effective delay saturates rather than wrapping when dither pushes it past the counter range.
  always_comb begin
    delay_sum = {1'b0, cfg_delay_q} + (CNT_W+1)'(dither_r);
    delay_eff = delay_sum[CNT_W] ? '1 : delay_sum[CNT_W-1:0];
    width_eff = (cfg_width_q == '0) ? CNT_ONE : cfg_width_q;
    gap_eff   = (cfg_gap_q == '0) ? CNT_ONE : cfg_gap_q;
    count_eff = (cfg_count_q == '0) ? PULSES_W'(1) : cfg_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_idx_q <= '0;
      cfg_edge_q  <= 1'b0;
      cfg_delay_q <= '0;
      cfg_width_q <= '0;
      cfg_gap_q   <= '0;
      cfg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_idx_q <= pulse_idx_d;
      if (latch_cfg) begin
        cfg_edge_q  <= cfg_edge;
        cfg_delay_q <= cfg_delay;
        cfg_width_q <= cfg_width;
        cfg_gap_q   <= cfg_gap;
        cfg_count_q <= cfg_count;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_idx_d = pulse_idx_q;
    latch_cfg   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d     = S_ARMED;
          latch_cfg   = 1'b1;
          pulse_idx_d = '0;
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (edge_q) begin
          if (delay_eff == '0) begin
            state_d = S_PULSE;
            cnt_d   = width_eff;
          end else begin
            state_d = S_DELAY;
            cnt_d   = delay_eff;
          end
        end
      end
      S_DELAY: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_PULSE;
          cnt_d   = width_eff;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          if (pulse_idx_q < (count_eff - PULSES_W'(1))) begin
            state_d     = S_GAP;
            cnt_d       = gap_eff;
            pulse_idx_d = pulse_idx_q + PULSES_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_PULSE;
          cnt_d   = width_eff;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (!arm && trig_idle) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    glitch_d       = (state_d == S_PULSE);
    busy_d         = (state_d == S_ARMED) || (state_d == S_DELAY) ||
                     (state_d == S_PULSE) || (state_d == S_GAP);
    delay_active_d = (state_d == S_DELAY);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q       <= 1'b0;
      busy_q         <= 1'b0;
      delay_active_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      glitch_q       <= glitch_d;
      busy_q         <= busy_d;
      delay_active_q <= delay_active_d;
      done_q         <= done_d;
    end
  end

  assign glitch       = glitch_q;
  assign busy         = busy_q;
  assign delay_active = delay_active_q;
  assign done         = done_q;
  assign pulse_idx    = pulse_idx_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: timeline model of the pulse train checked every cycle, plus directed literals.
module tb_glitch_sequencer;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, arm, trigger, cfg_edge;
  logic [31:0] cfg_delay, cfg_width, cfg_gap;
  logic [7:0]  cfg_count;
  logic        glitch, busy, delay_active, done;
  logic [7:0]  pulse_idx;

  always #5 clk = ~clk;

  glitch_sequencer #(.CNT_W(32), .PULSES_W(8), .SYNC_STAGES(S), .DITHER_W(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger(trigger), .cfg_edge(cfg_edge),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .glitch(glitch), .busy(busy), .delay_active(delay_active), .done(done), .pulse_idx(pulse_idx)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the sequence is a timeline fixed at the detection edge.
  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mst_t;
  mst_t     mst = M_IDLE;
  bit       hist [S+3];
  bit       m_pol;
  longint   m_D, m_W, m_G, m_N, m_f, m_doneT, dly, rel, per;
  bit       e_glitch, e_busy, e_dly, e_done;
  longint   e_pidx;
  bit [15:0] lf = 16'hACE1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mst = M_IDLE;
      foreach (hist[i]) hist[i] = 1'b0;
      m_pol = 1'b0;
      {e_glitch, e_busy, e_dly, e_done} = '0;
      e_pidx = 0;
      lf = 16'hACE1;
    end else begin
      for (int i = S + 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = trigger;
      case (mst)
        M_IDLE: if (arm) begin
          m_pol = cfg_edge;
          m_D = longint'(cfg_delay);
          m_W = (cfg_width == 0) ? 1 : longint'(cfg_width);
          m_G = (cfg_gap == 0) ? 1 : longint'(cfg_gap);
          m_N = (cfg_count == 0) ? 1 : longint'(cfg_count);
          e_pidx = 0;
          mst = M_ARMED;
        end
        M_ARMED: begin
          if (!arm) mst = M_IDLE;
          else if (m_pol ? (hist[S+2] && !hist[S+1]) : (hist[S+1] && !hist[S+2])) begin
`ifdef GLITCH_SEQ_DITHER_EN
            dly = m_D + longint'(lf % 16);
            if (dly > 64'hFFFF_FFFF) dly = 64'hFFFF_FFFF;
`else
            dly = m_D;
`endif
            m_f = cyc + dly;
            m_doneT = m_f + (m_N - 1) * (m_W + m_G) + m_W;
            mst = M_RUN;
          end
        end
        M_RUN: if (!arm) mst = M_IDLE;
        M_DONE: if (!arm && hist[S] == m_pol) mst = M_IDLE;
        default: mst = M_IDLE;
      endcase
      if (mst == M_RUN && cyc >= m_doneT) begin
        mst = M_DONE;
        e_pidx = m_N - 1;
      end
      e_glitch = 0;
      e_dly = 0;
      if (mst == M_RUN) begin
        if (cyc < m_f) e_dly = 1;
        else begin
          rel = cyc - m_f;
          per = m_W + m_G;
          if ((rel % per) < m_W) begin
            e_glitch = 1;
            e_pidx = rel / per;
          end else e_pidx = rel / per + 1;
        end
      end
      e_busy = (mst == M_ARMED) || (mst == M_RUN);
      e_done = (mst == M_DONE);
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("glitch", glitch, e_glitch);
      chk("busy", busy, e_busy);
      chk("delay_active", delay_active, e_dly);
      chk("done", done, e_done);
      chk("pulse_idx", pulse_idx, e_pidx);
    end
  end

  task automatic wait_until(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int b = 0;
    arm = 0;
    trigger = m_pol;
    while (mst != M_IDLE && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_wait: sequencer still active after %0d cycles", b);
    end
  endtask

  task automatic arm_with(input int d, input int w, input int g, input int n, input bit e);
    repeat (S + 3) @(negedge clk);
    cfg_delay = d; cfg_width = w; cfg_gap = g; cfg_count = n[7:0]; cfg_edge = e;
    arm = 1;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; arm = 0; trigger = 0; cfg_edge = 0;
    cfg_delay = 0; cfg_width = 0; cfg_gap = 0; cfg_count = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 0;
  endtask

  longint k, c;
  int     dl [2][64];
  int     ndist;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_glitch", glitch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pidx", pulse_idx, 0);

    // Single pulse, rising edge
    arm_with(10, 3, 2, 1, 0);
    trigger = 1; k = cyc + 1;
    wait_until(k + 12); chk("t1_pre", glitch, 0);
    wait_until(k + 13); chk("t1_first", glitch, 1);
    wait_until(k + 15); chk("t1_last", glitch, 1);
    wait_until(k + 16); chk("t1_end", glitch, 0); chk("t1_done", done, 1); chk("t1_busy", busy, 0);

    // Four back-to-back single-cycle pulses
    wait_idle();
    arm_with(0, 1, 0, 4, 0);
    trigger = 1; k = cyc + 1;
    wait_until(k + 3); chk("t2_p0", glitch, 1); chk("t2_i0", pulse_idx, 0);
    wait_until(k + 4); chk("t2_gap", glitch, 0); chk("t2_i1", pulse_idx, 1);
    wait_until(k + 9); chk("t2_p3", glitch, 1); chk("t2_i3", pulse_idx, 3);
    wait_until(k + 10); chk("t2_done", done, 1); chk("t2_idone", pulse_idx, 3);

    // Falling-edge trigger
    wait_idle();
    arm_with(10, 3, 2, 1, 1);
    trigger = 1;
    repeat (12) @(negedge clk);
    chk("t3_rise_ign", delay_active, 0); chk("t3_armed", busy, 1);
    trigger = 0; k = cyc + 1;
    wait_until(k + 12); chk("t3_pre", glitch, 0);
    wait_until(k + 13); chk("t3_first", glitch, 1);
    wait_until(k + 15); chk("t3_last", glitch, 1);
    wait_until(k + 16); chk("t3_done", done, 1);
    arm = 0;
    repeat (5) @(negedge clk);
    chk("t3_hold", done, 1);
    trigger = 1; c = cyc;
    wait_until(c + 2); chk("t3_still", done, 1);
    wait_until(c + 3); chk("t3_exit", done, 0);

    // Abort during a long delay, then re-arm with new config
    trigger = 0;
    arm_with(1000, 2, 1, 1, 0);
    trigger = 1; k = cyc + 1;
    wait_until(k + 503); chk("t4_delay", delay_active, 1);
    arm = 0;
    wait_until(k + 504); chk("t4_abort_busy", busy, 0); chk("t4_abort_dly", delay_active, 0);
    wait_until(k + 540); chk("t4_no_glitch", glitch, 0); chk("t4_no_done", done, 0);
    trigger = 0;
    arm_with(5, 2, 1, 2, 0);
    trigger = 1; k = cyc + 1;
    wait_until(k + 7); chk("t4b_pre", glitch, 0);
    wait_until(k + 8); chk("t4b_p0", glitch, 1);
    wait_until(k + 10); chk("t4b_gap", glitch, 0); chk("t4b_i1", pulse_idx, 1);
    wait_until(k + 11); chk("t4b_p1", glitch, 1);
    wait_until(k + 13); chk("t4b_done", done, 1);

    // Reset in the middle of a wide pulse
    wait_idle();
    arm_with(3, 20, 1, 1, 0);
    trigger = 1; k = cyc + 1;
    wait_until(k + 10); chk("t5_in_pulse", glitch, 1);
    rst = 1; arm = 0;
    wait_until(k + 11);
    chk("t5_glitch", glitch, 0); chk("t5_busy", busy, 0); chk("t5_pidx", pulse_idx, 0);
    rst = 0; trigger = 0;
    repeat (6) @(negedge clk);
    trigger = 1;
    repeat (10) @(negedge clk);
    chk("t5_ignored", busy, 0); chk("t5_quiet", glitch, 0);

    // Randomised sequences with mid-run config changes and occasional aborts
    for (int t = 0; t < 40; t++) begin
      wait_idle();
      arm_with($urandom_range(20), $urandom_range(5), $urandom_range(4),
               $urandom_range(5), 1'($urandom_range(1)));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(3) == 0) trigger = ~trigger;
        cfg_delay = $urandom_range(50); cfg_width = $urandom_range(9);
        cfg_gap = $urandom_range(9); cfg_count = 8'($urandom_range(9));
        cfg_edge = 1'($urandom_range(1));
        if ($urandom_range(59) == 0) arm = 0;
        @(negedge clk);
        if (mst == M_DONE) break;
      end
    end

`ifdef GLITCH_SEQ_DITHER_EN
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 64; i++) begin
        int b;
        wait_idle();
        arm_with(10, 1, 0, 1, 0);
        trigger = 1; k = cyc + 1;
        b = 0;
        while (glitch !== 1'b1 && b < 60) begin
          @(negedge clk);
          b++;
        end
        dl[r][i] = int'(cyc - (k + 3));
        chk("dither_range", (dl[r][i] >= 10 && dl[r][i] <= 25), 1);
      end
    end
    ndist = 0;
    for (int i = 0; i < 64; i++) begin
      chk("dither_repeat", dl[1][i], dl[0][i]);
      if (dl[0][i] != dl[0][0]) ndist++;
    end
    chk("dither_distinct", ndist > 0, 1);
`endif

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Parametrised successor to the single-shot glitch generator.
- Produces a programmable train of N glitch pulses after a trigger edge. Delay, pulse width, inter-pulse gap, pulse count and trigger edge are runtime registers, not elaboration constants.
- Adds an arm/abort level, a trigger synchroniser and status outputs.
- Runs in the PLL clock domain. Drives the glitch output pin and the board indicator LEDs.

Parameters:
- CNT_W, 32, width of the delay/width/gap counters and config fields.
- PULSES_W, 8, width of the pulse-count config and pulse index.
- SYNC_STAGES, 2, flops in the trigger synchroniser (minimum 2).
- DITHER_W, 4, width of the random extra delay (used only with the optional feature).

Ports:
- clk  in  1  PLL clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level. 1 = armed request; 0 = abort or idle.
- trigger  in  1  asynchronous external trigger.
- cfg_edge  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- cfg_delay  in  CNT_W  delay cycles D from trigger detect to first pulse.
- cfg_width  in  CNT_W  pulse high cycles W.
- cfg_gap  in  CNT_W  low cycles G between pulses.
- cfg_count  in  PULSES_W  number of pulses N.
- glitch  out  1  registered glitch output.
- busy  out  1  high in ARMED, DELAY, PULSE, GAP.
- delay_active  out  1  high in DELAY.
- done  out  1  high in DONE.
- pulse_idx  out  PULSES_W  0-based index of the current or last pulse.

Behaviour:
- Reset: state = IDLE. All outputs 0. Synchroniser, edge register, counters and latched config all 0.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE. All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- IDLE:
  - On arm=1, latch all cfg_* into shadow registers and go to ARMED.
  - cfg_* changes after latching have no effect until the next arm.
- Trigger path:
  - Raw trigger passes through SYNC_STAGES flops.
  - An edge is detected when the synchronised value differs from its previous sample in the direction selected by the latched cfg_edge.
  - Edges are ignored outside ARMED.
- ARMED:
  - On a detected edge, go to DELAY with the counter loaded to D.
  - If D = 0, go directly to PULSE.
- Latency:
  - Raw trigger is stable from clk edge k.
  - glitch is high from edge k + SYNC_STAGES + 1 + D.
  - glitch stays high for exactly W' = max(W,1) cycles.
- DELAY: decrement each cycle. On the cycle the counter reaches 1, next state is PULSE.
- PULSE:
  - glitch = 1 for W' cycles.
  - Then, if pulse_idx + 1 < N', go to GAP and increment pulse_idx. Otherwise go to DONE.
  - N' = max(N,1).
- GAP: glitch = 0 for G' = max(G,1) cycles, then go to PULSE. G = 0 still produces one low cycle, so adjacent pulses never merge.
- DONE:
  - done = 1, glitch = 0.
  - Go to IDLE when arm = 0 AND the synchronised trigger is at its inactive level (0 for rising, 1 for falling).
  - Holding arm high keeps DONE; there is no auto-rearm.
- Abort: arm = 0 in ARMED, DELAY, PULSE or GAP gives IDLE on the next edge.
  - glitch drops on that edge.
  - done is never asserted.
  - pulse_idx is held.
- Trigger edges during DELAY, PULSE or GAP are ignored; no retrigger.
- rst mid-sequence: glitch goes low on that edge and all state returns to reset values.
- Counters are CNT_W wide and unsigned. D = 2^CNT_W − 1 is legal and must not wrap early.

Optional Feature:
- Macro: GLITCH_SEQ_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) advances every cycle.
  - On trigger detect, the low DITHER_W bits R are added to D, giving an effective delay of D + R, with R in [0, 2^DITHER_W − 1].
  - The sum is computed at CNT_W + 1 bits and saturated at 2^CNT_W − 1.
- When undefined: no LFSR exists and the delay is exactly D.

Test Plan:
1. rst; D=10, W=3, G=2, N=1, rising; arm=1; trigger 0→1 at edge k → glitch high on edges k+13..k+15; done=1 from k+16; busy low with done.
2. D=0, W=1, G=0, N=4 → four 1-cycle pulses separated by 1-cycle lows; pulse_idx steps 0,1,2,3; done after the 4th.
3. cfg_edge=1, trigger idling high: a rising edge produces no response; a falling edge gives the same timing as test 1. DONE exits only after arm=0 and trigger back high.
4. D=1000: arm dropped at delay cycle 500 → IDLE next edge; glitch never asserts; done stays 0. Re-arm with fresh cfg → new values used.
5. rst asserted mid-PULSE of a W=20 pulse → glitch=0 on the next edge; all outputs 0; a trigger without re-arm is ignored.
6. With GLITCH_SEQ_DITHER_EN, 64 triggers at D=10 → every delay in [10,25], more than one distinct value seen, and the sequence is identical across two runs from rst.
